// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multipliers: FSM states, digit-select codes, digit count.
// Purely declarative; no latency or flow control of its own.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        ZERO,
        PM1,
        PM2,
        NM1,
        NM2
    } sel_e;

    localparam int W_DEF  = 8;
    localparam int DIGITS = W_DEF / 2;

    function automatic int digits(input int w);
        return w / 2;
    endfunction

endpackage

// File: rtl/booth_r4_seq_if.sv
// Operand request / product result bundle for the sequential Booth multiplier.
// Request side uses start/ready; result side is a one-cycle valid pulse with no backpressure.
interface booth_r4_seq_if #(
    parameter int W = 8
);
    logic             start;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             ready;
    logic             busy;
    logic             valid;
    logic [2*W-1:0]   p;

    modport master (
        output start, a, b,
        input  ready, busy, valid, p
    );

    modport slave (
        input  start, a, b,
        output ready, busy, valid, p
    );
endinterface

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth digit recoder: {b[i+1], b[i], b[i-1]} to a partial-product select code.
// Combinational, zero latency, no flow control.
module booth_r4_enc
    import booth_pkg::*;
(
    input  logic [2:0] digit_i,
    output sel_e       sel_o
);

    always_comb begin
        sel_o = ZERO;
        case (digit_i)
            3'b001, 3'b010: sel_o = PM1;
            3'b011:         sel_o = PM2;
            3'b100:         sel_o = NM2;
            3'b101, 3'b110: sel_o = NM1;
            default:        sel_o = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_r4_seq.sv
// Sequential signed radix-4 Booth multiplier, one digit per clock; result W/2 edges after acceptance.
// Takes a request only when ready (IDLE/DONE); starts during RUN are dropped, result is not backpressured.
module booth_r4_seq
    import booth_pkg::*;
#(
    parameter int W = 8
) (
    input  logic          clk,
    input  logic          rst,
    booth_r4_seq_if.slave bus
);

    localparam int DIG = digits(W);
    localparam int CW  = (DIG > 1) ? $clog2(DIG) : 1;
    localparam int HW  = W + 2;
    localparam int AW  = 2 * W + 3;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [W-1:0]     m_q, m_d;
    logic [2*W-1:0]   p_q, p_d;
    logic             valid_q, valid_d;

    sel_e             sel;
    logic [HW-1:0]    m_ext;
    logic [HW-1:0]    pp;
    logic             neg;
    logic [HW-1:0]    hi_new;
    logic [AW-1:0]    shifted;
    logic             last;

    // Digit is taken from the two low multiplier bits plus the appended x bit.
    booth_r4_enc u_enc (
        .digit_i (acc_q[2:0]),
        .sel_o   (sel)
    );

    // Two guard bits in hi keep +/-2m from wrapping before the shift.
    always_comb begin
        m_ext = {{2{m_q[W-1]}}, m_q};
        pp    = '0;
        neg   = 1'b0;
        case (sel)
            PM1: pp = m_ext;
            PM2: pp = m_ext << 1;
            NM1: begin
                pp  = ~m_ext;
                neg = 1'b1;
            end
            NM2: begin
                pp  = ~(m_ext << 1);
                neg = 1'b1;
            end
            default: pp = '0;
        endcase
        hi_new  = acc_q[AW-1:W+1] + pp + HW'(neg);
        shifted = $signed({hi_new, acc_q[W:0]}) >>> 2;
    end

    assign last = (cnt_q == CW'(DIG - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        m_d     = m_q;
        p_d     = p_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    m_d     = bus.a;
                    acc_d   = {{HW{1'b0}}, bus.b, 1'b0};
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = shifted;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d = DONE;
                    p_d     = shifted[2*W:1];
                    valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            m_q     <= '0;
            p_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            p_q     <= p_d;
            valid_q <= valid_d;
        end
    end

    assign bus.ready = (state_q == IDLE) || (state_q == DONE);
    assign bus.busy  = (state_q == RUN);
    assign bus.valid = valid_q;
    assign bus.p     = p_q;

endmodule
